// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable clock-enable / scan-select generator.
package freq_div_pkg;

  localparam int unsigned DIV_DEFAULT_C = 32'd49_999_999;
  localparam int unsigned SCAN_DIV_C    = 32'd32_767;

  // Select width for n scan positions; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/freq_div_param_tc_counter.sv
// Terminal-count counter: counts enabled cycles up to term_i, then wraps and strobes tc_o.
// wrap_o is the combinational "this edge wraps" flag so a caller can register an edge in lockstep with tc_o.
module tc_counter
  import freq_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] term_i,
  output logic         wrap_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tc_q, tc_d;

  // Load clears the count and beats enable; otherwise count up to the terminal value.
  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    wrap_o = 1'b0;
    if (load_i) begin
      cnt_d = '0;
    end else if (!en_i) begin
      cnt_d = cnt_q;
    end else if (cnt_q == term_i) begin
      cnt_d  = '0;
      tc_d   = 1'b1;
      wrap_o = 1'b1;
    end else begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/freq_div_param.sv
// Runtime-programmable clock divider with tick strobe plus an N-way display scan selector.
// Define FREQ_DIV_SCAN_EN to build the scan channel; otherwise scan_sel and scan_tick are tied to 0.
module freq_div_param
  import freq_div_pkg::*;
#(
  parameter int          CNT_W       = 27,
  parameter int unsigned DIV_DEFAULT = DIV_DEFAULT_C,
  parameter int          SCAN_CNT_W  = 15,
  parameter int unsigned SCAN_DIV    = SCAN_DIV_C,
  parameter int          N_SCAN      = 4,
  parameter int          SEL_W       = sel_width(N_SCAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_val,
  output logic             clk_out,
  output logic             tick,
  output logic [SEL_W-1:0] scan_sel,
  output logic             scan_tick
);

  logic [CNT_W-1:0] div_q, div_d;
  logic             clk_out_q, clk_out_d;
  logic             main_wrap_s;
  logic             main_tc_s;

  tc_counter #(.W(CNT_W)) u_main (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .load_i (div_load),
    .term_i (div_q),
    .wrap_o (main_wrap_s),
    .tc_o   (main_tc_s)
  );

  // clk_out flips on the same edge that registers the tick strobe.
  always_comb begin
    div_d     = div_q;
    clk_out_d = clk_out_q;
    if (div_load) begin
      div_d = div_val;
    end else if (main_wrap_s) begin
      clk_out_d = ~clk_out_q;
    end else begin
      clk_out_d = clk_out_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= CNT_W'(DIV_DEFAULT);
      clk_out_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      clk_out_q <= clk_out_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = main_tc_s;

`ifdef FREQ_DIV_SCAN_EN
  logic             scan_wrap_s;
  logic             scan_tc_s;
  logic [SEL_W-1:0] sel_q, sel_d;

  tc_counter #(.W(SCAN_CNT_W)) u_scan (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (en),
    .load_i (1'b0),
    .term_i (SCAN_CNT_W'(SCAN_DIV)),
    .wrap_o (scan_wrap_s),
    .tc_o   (scan_tc_s)
  );

  always_comb begin
    sel_d = sel_q;
    if (scan_wrap_s) begin
      if (sel_q == SEL_W'(N_SCAN - 1)) begin
        sel_d = '0;
      end else begin
        sel_d = sel_q + SEL_W'(1);
      end
    end else begin
      sel_d = sel_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign scan_sel  = sel_q;
  assign scan_tick = scan_tc_s;
`else
  assign scan_sel  = '0;
  assign scan_tick = 1'b0;
`endif

endmodule
